// File: rtl/reg_file_param.sv
// Parameterised dual-read, single-write register file with a sequential clear engine.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_param #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Daddr,
  input  logic [WIDTH-1:0]  Ddata,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  output logic [WIDTH-1:0]  Adata,
  output logic [WIDTH-1:0]  Bdata,
  input  logic              CLR,
  output logic              BUSY,
  output logic              DONE
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  regs_q [DEPTH];

  // CLR has priority over WR in IDLE; in CLEAR only the pointer touches storage.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (CLR) begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end else if (WR) begin
          regs_q[Daddr] <= Ddata;
        end
      end else begin
        regs_q[ptr_q] <= '0;
        if (ptr_q == LAST) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          ptr_q <= ptr_q + 1'b1;
        end
      end
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

`ifdef REGFILE_BYPASS_EN
  // Forward only when the write will actually land on the coming edge.
  logic fwd_en;
  assign fwd_en = (state_q == IDLE) && WR && !CLR;
  assign Adata  = (fwd_en && (Aaddr == Daddr)) ? Ddata : regs_q[Aaddr];
  assign Bdata  = (fwd_en && (Baddr == Daddr)) ? Ddata : regs_q[Baddr];
`else
  assign Adata = regs_q[Aaddr];
  assign Bdata = regs_q[Baddr];
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised bench for reg_file_param with a behavioural model, plus a WIDTH=8/ADDR_W=3
// instance used for the mid-clear asynchronous reset scenario.
`timescale 1ns/1ps
module tb_reg_file_param;

  localparam int W  = 4;
  localparam int AW = 2;
  localparam int D  = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          wr = 1'b0, clr = 1'b0;
  logic [AW-1:0] daddr = '0, aaddr = '0, baddr = '0;
  logic [W-1:0]  ddata = '0;
  logic [W-1:0]  adata, bdata;
  logic          busy, done;

  logic       b_rst_n = 1'b1;
  logic       b_wr = 1'b0, b_clr = 1'b0;
  logic [2:0] b_daddr = '0, b_aaddr = '0, b_baddr = '0;
  logic [7:0] b_ddata = '0;
  logic [7:0] b_adata, b_bdata;
  logic       b_busy, b_done;

  reg_file_param #(.WIDTH(W), .ADDR_W(AW)) u_dut (
    .CLK(clk), .RSTn(rst_n), .WR(wr), .Daddr(daddr), .Ddata(ddata),
    .Aaddr(aaddr), .Baddr(baddr), .Adata(adata), .Bdata(bdata),
    .CLR(clr), .BUSY(busy), .DONE(done)
  );

  reg_file_param #(.WIDTH(8), .ADDR_W(3)) u_big (
    .CLK(clk), .RSTn(b_rst_n), .WR(b_wr), .Daddr(b_daddr), .Ddata(b_ddata),
    .Aaddr(b_aaddr), .Baddr(b_baddr), .Adata(b_adata), .Bdata(b_bdata),
    .CLR(b_clr), .BUSY(b_busy), .DONE(b_done)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: array contents plus "index still to clear" (-1 when idle).
  logic [W-1:0] m_mem [D];
  int           m_clr  = -1;
  bit           m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_clr  = -1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_clr >= 0) begin
        m_mem[m_clr] = '0;
        if (m_clr == D - 1) begin
          m_clr  = -1;
          m_done = 1'b1;
        end else begin
          m_clr = m_clr + 1;
        end
      end else if (clr) begin
        m_clr = 0;
      end else if (wr) begin
        m_mem[daddr] = ddata;
      end
    end
  end

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (BYP && (m_clr < 0) && wr && !clr && (a == daddr)) return ddata;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("Adata", 32'(adata), 32'(m_read(aaddr)));
      check("Bdata", 32'(bdata), 32'(m_read(baddr)));
      check("BUSY",  32'(busy),  32'(m_clr >= 0));
      check("DONE",  32'(done),  32'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    rst_n   = 1'b0;
    b_rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    tick();
    for (int i = 0; i < D; i++) begin
      aaddr = AW'(i);
      baddr = AW'(D - 1 - i);
      #1;
      check("rst_A", 32'(adata), 32'h0);
      check("rst_B", 32'(bdata), 32'h0);
    end
    check("rst_BUSY", 32'(busy), 32'h0);
    check("rst_DONE", 32'(done), 32'h0);
    tick();

    // Release reset and write on the very first edge.
    rst_n   = 1'b1;
    b_rst_n = 1'b1;
    wr = 1'b1; daddr = 2'd1; ddata = 4'hA;
    tick();
    daddr = 2'd2; ddata = 4'h5;
    tick();
    wr = 1'b0; aaddr = 2'd1; baddr = 2'd2;
    #1;
    check("wr_A1", 32'(adata), 32'hA);
    check("wr_B2", 32'(bdata), 32'h5);
    aaddr = 2'd0; baddr = 2'd3;
    #1;
    check("wr_A0", 32'(adata), 32'h0);
    check("wr_B3", 32'(bdata), 32'h0);

    // Fill 1..4 and run a full clear.
    tick();
    wr = 1'b1;
    for (int i = 0; i < D; i++) begin
      daddr = AW'(i); ddata = W'(i + 1);
      tick();
    end
    wr = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < D; c++) begin
      aaddr = AW'(c);
      baddr = (c > 0) ? AW'(c - 1) : AW'(D - 1);
      #1;
      check("clr_BUSY", 32'(busy), 32'h1);
      check("clr_A", 32'(adata), 32'(c + 1));
      check("clr_B", 32'(bdata), (c > 0) ? 32'h0 : 32'h4);
      tick();
    end
    check("clr_end_BUSY", 32'(busy), 32'h0);
    check("clr_end_DONE", 32'(done), 32'h1);
    tick();
    check("clr_post_DONE", 32'(done), 32'h0);
    for (int i = 0; i < D; i++) begin
      aaddr = AW'(i);
      #1;
      check("clr_zero", 32'(adata), 32'h0);
    end

    // WR and CLR held during CLEAR must not modify or extend anything.
    tick();
    wr = 1'b1; daddr = 2'd3; ddata = 4'h9;
    tick();
    wr = 1'b0; clr = 1'b1;
    tick();
    wr = 1'b1; daddr = 2'd3; ddata = 4'hF; aaddr = 2'd3;
    repeat (3) tick();
    #1;
    check("clrwr_A3", 32'(adata), 32'h9);
    wr = 1'b0; clr = 1'b0;
    tick();
    check("clrwr_BUSY", 32'(busy), 32'h0);
    check("clrwr_DONE", 32'(done), 32'h1);
    check("clrwr_A3z", 32'(adata), 32'h0);

    // CLR together with WR on the DONE cycle: restart, write dropped.
    wr = 1'b1; clr = 1'b1; daddr = 2'd3; ddata = 4'hF; aaddr = 2'd3;
    #1;
    check("both_A3", 32'(adata), 32'h0);
    tick();
    wr = 1'b0; clr = 1'b0;
    check("restart_BUSY", 32'(busy), 32'h1);
    repeat (D) tick();
    check("restart_DONE", 32'(done), 32'h1);
    check("both_A3z", 32'(adata), 32'h0);

    // Same-cycle read of a register being written.
    wr = 1'b1; daddr = 2'd2; ddata = 4'h7; aaddr = 2'd2; baddr = 2'd2;
    #1;
    check("byp_A", 32'(adata), BYP ? 32'h7 : 32'h0);
    check("byp_B", 32'(bdata), BYP ? 32'h7 : 32'h0);
    tick();
    wr = 1'b0;
    #1;
    check("byp_next_A", 32'(adata), 32'h7);

    // Randomised traffic with occasional mid-cycle reset.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        wr = 1'b0; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_BUSY", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
      end
      wr    = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 19) == 0);
      daddr = AW'($urandom);
      ddata = W'($urandom);
      aaddr = AW'($urandom);
      baddr = AW'($urandom);
      tick();
    end
    wr = 1'b0; clr = 1'b0;

    // Wide instance: reset dropped between edges in the middle of a clear.
    b_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_daddr = 3'(i); b_ddata = 8'(17 * (i + 1));
      tick();
    end
    b_wr = 1'b0; b_aaddr = 3'd5;
    #1;
    check("big_wr_A5", 32'(b_adata), 32'h66);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    repeat (2) tick();
    b_aaddr = 3'd2; b_baddr = 3'd1;
    #1;
    check("big_mid_A2", 32'(b_adata), 32'h33);
    check("big_mid_B1", 32'(b_bdata), 32'h0);
    check("big_mid_BUSY", 32'(b_busy), 32'h1);
    #1 b_rst_n = 1'b0;
    #1;
    check("big_rst_BUSY", 32'(b_busy), 32'h0);
    check("big_rst_DONE", 32'(b_done), 32'h0);
    for (int i = 0; i < 8; i++) begin
      b_aaddr = 3'(i); b_baddr = 3'(7 - i);
      #1;
      check("big_rst_A", 32'(b_adata), 32'h0);
      check("big_rst_B", 32'(b_bdata), 32'h0);
    end
    tick();
    b_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("big_noDONE", 32'(b_done), 32'h0);
      check("big_noBUSY", 32'(b_busy), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      b_aaddr = 3'(i);
      #1;
      check("big_zero", 32'(b_adata), 32'h0);
    end

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
